// File: rtl/decodificador_funcionalidade.sv
// Sequential 3-bit functionality-code decoder: drives one of seven one-hot select
// lines for HOLD_CYCLES cycles after a code is accepted; flags code 000 and supports abort.
module decodificador_funcionalidade #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cf_in,
  input  logic       cf_valid,
  output logic       cf_ready,
  input  logic       abort,
  output logic [6:0] sel_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LOAD_VAL = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] sel_q, sel_d;
  logic       err_q, err_d;
  logic [2:0] idx;
  logic [6:0] onehot;

  // Encoder bit order is reversed relative to the select index.
  always_comb begin
    idx    = {cf_in[0], cf_in[1], cf_in[2]};
    onehot = 7'd0;
    case (idx)
      3'd1:    onehot = 7'b0000001;
      3'd2:    onehot = 7'b0000010;
      3'd3:    onehot = 7'b0000100;
      3'd4:    onehot = 7'b0001000;
      3'd5:    onehot = 7'b0010000;
      3'd6:    onehot = 7'b0100000;
      3'd7:    onehot = 7'b1000000;
      default: onehot = 7'd0;
    endcase
  end

  // Handshake: a code transfers on an edge with cf_valid && cf_ready; cf_ready
  // depends only on state (IDLE) so there is no path from cf_valid to cf_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cf_valid) begin
          if (idx != 3'd0) begin
            sel_d   = onehot;
            cnt_d   = LOAD_VAL;
            state_d = S_ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          sel_d   = 7'd0;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          sel_d   = 7'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        sel_d   = 7'd0;
        state_d = S_IDLE;
      end
      default: begin
        sel_d   = 7'd0;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign cf_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ACTIVE) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign sel_out   = sel_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_decodificador_funcionalidade.sv
// Bench for decodificador_funcionalidade: two instances (HOLD_CYCLES=4 and 1) checked
// every cycle against a timeline model, plus hand-computed literal expectations.
module tb_decodificador_funcionalidade;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index 0: HOLD=4, index 1: HOLD=1) ----------------
  logic [2:0] cfi [2];
  logic       cfv [2];
  logic       abt [2];
  logic       rdy [2];
  logic [6:0] sel [2];
  logic       bsy [2];
  logic       dne [2];
  logic       er  [2];
  logic [1:0] sdbg [2];

  decodificador_funcionalidade #(.HOLD_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .cf_in(cfi[0]), .cf_valid(cfv[0]), .cf_ready(rdy[0]),
    .abort(abt[0]), .sel_out(sel[0]), .busy(bsy[0]), .done(dne[0]), .err(er[0]),
    .state_dbg(sdbg[0])
  );

  decodificador_funcionalidade #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cf_in(cfi[1]), .cf_valid(cfv[1]), .cf_ready(rdy[1]),
    .abort(abt[1]), .sel_out(sel[1]), .busy(bsy[1]), .done(dne[1]), .err(er[1]),
    .state_dbg(sdbg[1])
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An activation is described by the cycle it started; the phase t counts cycles
  // since acceptance: 1..H select high, H+1 done, beyond that idle.
  int         cyc = 0;
  bit         act [2] = '{0, 0};
  int         acc [2] = '{0, 0};
  logic [6:0] oh_m [2] = '{7'd0, 7'd0};
  bit         err_e [2] = '{0, 0};

  function automatic int hold(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [6:0] dec(logic [2:0] code);
    int i;
    i = code[0] * 4 + code[1] * 2 + code[2];
    if (i == 0) return 7'd0;
    return 7'(1 << (i - 1));
  endfunction

  function automatic int phase(int d);
    if (!act[d]) return 0;
    return cyc - acc[d];
  endfunction

  function automatic bit m_busy(int d);
    int t;
    t = phase(d);
    return (t >= 1) && (t <= hold(d) + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int t;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        act[d]   <= 1'b0;
        err_e[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        t = phase(d);
        err_e[d] <= 1'b0;
        if (!m_busy(d)) begin
          act[d] <= 1'b0;
          if (cfv[d]) begin
            if (dec(cfi[d]) != 7'd0) begin
              act[d]  <= 1'b1;
              acc[d]  <= cyc;
              oh_m[d] <= dec(cfi[d]);
            end else begin
              err_e[d] <= 1'b1;
            end
          end
        end else if (t <= hold(d) && abt[d]) begin
          act[d] <= 1'b0;
        end
      end
      cyc <= cyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int t;
    int h;
    logic [6:0] es;
    for (int d = 0; d < 2; d++) begin
      t  = phase(d);
      h  = hold(d);
      es = (t >= 1 && t <= h) ? oh_m[d] : 7'd0;
      chk($sformatf("sel%0d", d),   32'(sel[d]), 32'(es));
      chk($sformatf("busy%0d", d),  32'(bsy[d]), 32'(m_busy(d)));
      chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(!m_busy(d)));
      chk($sformatf("done%0d", d),  32'(dne[d]), 32'(t == h + 1));
      chk($sformatf("err%0d", d),   32'(er[d]),  32'(err_e[d]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a code and holds it until it is taken; returns 1 time unit after the accept edge.
  task automatic send(int d, logic [2:0] code);
    int n;
    n = 0;
    cfv[d] = 1'b1;
    cfi[d] = code;
    while (!rdy[d] && n < 50) begin
      cycles(1);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_timeout dut%0d: ready %0b required 1", d, rdy[d]);
    end
    cycles(1);
    cfv[d] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] codes [7] = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
  logic [6:0] lits  [7] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                            7'b0010000, 7'b0100000, 7'b1000000};
  logic [2:0] bp_codes [8] = '{3'b011, 3'b101, 3'b000, 3'b110, 3'b001, 3'b111, 3'b010, 3'b101};

  initial begin
    for (int d = 0; d < 2; d++) begin
      cfi[d] = 3'b000;
      cfv[d] = 1'b0;
      abt[d] = 1'b0;
    end
    #12;
    // reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_sel",   32'(sel[d]), 32'd0);
      chk("rst_ready", 32'(rdy[d]), 32'd1);
      chk("rst_busy",  32'(bsy[d]), 32'd0);
      chk("rst_done",  32'(dne[d]), 32'd0);
      chk("rst_err",   32'(er[d]),  32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // all valid codes, HOLD=4
    for (int i = 0; i < 7; i++) begin
      chk("model_dec", 32'(dec(codes[i])), 32'(lits[i]));
      send(0, codes[i]);
      chk("code_sel", 32'(sel[0]), 32'(lits[i]));
      cycles(3);
      chk("code_sel_last", 32'(sel[0]), 32'(lits[i]));
      cycles(1);
      chk("code_done", 32'(dne[0]), 32'd1);
      chk("code_ready_low", 32'(rdy[0]), 32'd0);
      cycles(1);
      chk("code_ready_back", 32'(rdy[0]), 32'd1);
    end

    // invalid code then immediate 111
    send(0, 3'b000);
    chk("inv_err", 32'(er[0]), 32'd1);
    chk("inv_sel", 32'(sel[0]), 32'd0);
    chk("inv_ready", 32'(rdy[0]), 32'd1);
    send(0, 3'b111);
    chk("after_inv_sel", 32'(sel[0]), 32'h40);
    chk("after_inv_err", 32'(er[0]), 32'd0);
    cycles(6);

    // abort on 2nd ACTIVE cycle
    send(0, 3'b110);
    cycles(1);
    abt[0] = 1'b1;
    cycles(1);
    abt[0] = 1'b0;
    chk("abort_sel", 32'(sel[0]), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    cycles(5);

    // abort held high in IDLE is ignored
    abt[0] = 1'b1;
    cycles(3);
    chk("abort_idle_busy", 32'(bsy[0]), 32'd0);
    send(0, 3'b010);
    abt[0] = 1'b0;
    chk("abort_idle_sel", 32'(sel[0]), 32'h02);
    cycles(6);

    // back-pressure: valid held with changing code while busy
    send(0, 3'b100);
    cfv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cfi[0] = bp_codes[i];
      cycles(1);
    end
    cfv[0] = 1'b0;
    cycles(8);

    // HOLD_CYCLES=1
    send(1, 3'b001);
    chk("h1_sel", 32'(sel[1]), 32'h08);
    cycles(1);
    chk("h1_sel_off", 32'(sel[1]), 32'd0);
    chk("h1_done", 32'(dne[1]), 32'd1);
    cycles(1);
    chk("h1_ready", 32'(rdy[1]), 32'd1);
    chk("h1_done_off", 32'(dne[1]), 32'd0);
    cycles(2);

    // asynchronous reset mid-ACTIVE
    send(0, 3'b101);
    send(1, 3'b111);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_sel",   32'(sel[d]), 32'd0);
      chk("arst_busy",  32'(bsy[d]), 32'd0);
      chk("arst_ready", 32'(rdy[d]), 32'd1);
      chk("arst_done",  32'(dne[d]), 32'd0);
      chk("arst_err",   32'(er[d]),  32'd0);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    send(0, 3'b011);
    chk("post_rst_sel", 32'(sel[0]), 32'h20);
    cycles(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decodificador_funcionalidade.md
# decodificador_funcionalidade

Sequential 3-bit functionality-code decoder: accepts a code over a valid/ready handshake and drives the matching one of seven one-hot select lines (A..G) for a fixed number of cycles. It sits downstream of the functionality encoder and uses the same bit ordering, so encoder output wired to `cf_in` re-creates the original select line. Invalid codes are flagged. A running activation can be aborted.

## Interface
- `HOLD_CYCLES`, default 4: number of cycles a select line stays asserted. Legal range is 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cf_in` input 3: functionality code, in the encoder's bit order.
- `cf_valid` input 1: `cf_in` is valid this cycle.
- `cf_ready` output 1: the block accepts a code this cycle.
- `abort` input 1: synchronous cancel of an active selection.
- `sel_out` output 7: one-hot select. `sel_out[0]`=A ... `sel_out[6]`=G. Registered.
- `busy` output 1: a selection is in progress (state ACTIVE or DONE).
- `done` output 1: one-cycle pulse when an activation completes normally.
- `err` output 1: one-cycle pulse after an invalid code is accepted.

## Operation
- **Code map**, written as `cf_in[2:0]`:
  - 100 → A; 010 → B; 110 → C; 001 → D; 101 → E; 011 → F; 111 → G.
  - 000 is invalid.
  - Equivalently, the index is {cf_in[0],cf_in[1],cf_in[2]} (1..7), and the line driven is `sel_out[index-1]`.
- **Handshake:** a code is accepted on an edge where `cf_valid` and `cf_ready` are both 1. `cf_ready` = (state==IDLE). It is combinational from state only and never depends on `cf_valid`.
- **FSM states:** IDLE, ACTIVE, DONE. The reset state is IDLE.
- **IDLE:**
  - Valid code accepted: latch the decoded one-hot into `sel_out`, load the counter with HOLD_CYCLES-1, go to ACTIVE.
  - Code 000 accepted: `err`=1 for the next cycle. State stays IDLE, `sel_out` stays 0, `cf_ready` stays 1.
  - `abort` is ignored in IDLE.
- **ACTIVE:**
  - `sel_out` holds the latched value and the counter decrements each cycle.
  - When the counter is 0 at an edge: clear `sel_out`, go to DONE.
  - `abort`=1 at an edge: clear `sel_out`, go directly to IDLE. No `done` is produced and the counter is discarded. `abort` has priority over counter expiry in the same cycle.
- **DONE:** `done`=1 for exactly this cycle, `sel_out`=0, then go to IDLE unconditionally. `abort` is ignored in DONE.
- **Counter width:** 8 bits. The counter never wraps, because it is only decremented while nonzero.
- **Output invariant:** `sel_out` is either all-zero or exactly one-hot at all times.
- **Reset:** asserting `rst_n` low at any time, including mid-ACTIVE, immediately forces the following, with no `done` or `err` pulse:
  - state=IDLE and counter=0;
  - `sel_out`=0, `done`=0, `err`=0;
  - `busy`=0 and `cf_ready`=1.

## Timing
- Accept at edge k, then:
  - `sel_out` is one-hot in cycles k+1 .. k+HOLD_CYCLES;
  - `done`=1 in cycle k+HOLD_CYCLES+1;
  - `cf_ready`=1 again in cycle k+HOLD_CYCLES+2.
- Throughput is one code per HOLD_CYCLES+2 cycles.
- With HOLD_CYCLES=1: `sel_out` is high for exactly 1 cycle, then `done` the next cycle.
- Invalid code accepted at edge k: `err`=1 in cycle k+1 only. Another code can be accepted at edge k+1.
- `abort` sampled at edge m during ACTIVE: `sel_out`=0 and `cf_ready`=1 from cycle m+1.
- `busy`=1 exactly when state is ACTIVE or DONE.
- Output latency from accept is 1 cycle. There are no combinational paths from `cf_in`/`cf_valid` to any output.

## Test plan
- **Reset:** `rst_n`=0 → `sel_out`=0000000, `cf_ready`=1, `busy`=0, `done`=0, `err`=0.
- **All valid codes:** send each code 100,010,110,001,101,011,111 with HOLD_CYCLES=4.
  - `sel_out`= 0000001, 0000010, 0000100, 0001000, 0010000, 0100000, 1000000 respectively, each for exactly 4 cycles.
  - `done` pulses 1 cycle later.
  - `cf_ready` is low for 5 cycles (4 ACTIVE + 1 DONE).
- **Invalid code:** `cf_in`=000 with `cf_valid`=1 → `err` high exactly 1 cycle, `sel_out` stays 0, `cf_ready` stays 1. A following 111 is accepted on the next edge.
- **Abort:** code 110, `abort`=1 on the 2nd ACTIVE cycle → `sel_out` returns to 0 next cycle, `done` never asserts, `cf_ready`=1. `abort` held high in IDLE has no effect.
- **Back-pressure and HOLD_CYCLES=1:** hold `cf_valid`=1 with a changing `cf_in` while busy → nothing is accepted until `cf_ready`=1. With HOLD_CYCLES=1, code 001 gives `sel_out`=0001000 for 1 cycle, then `done`.
- **Asynchronous reset mid-ACTIVE:** drop `rst_n` between clock edges → all outputs clear immediately with no `done` or `err` pulse. After release, the next code is accepted normally.
